lfsr16_checker: RTL

//  Read-side checker for the 16-bit LFSR test pattern (x^16+x^15+x^13+x^4+1, shift-left).

---
 rtl/lfsr16_checker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/lfsr16_checker.sv
// Read-side checker for the x^16+x^15+x^13+x^4+1 pattern: self-seeds from the stream,
// verifies lock, then predicts every word and counts word/bit errors.
module lfsr16_checker #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CLR,
    input  logic             IN_VALID,
    input  logic [15:0]      IN_DATA,
    output logic             LOCKED,
    output logic             ERR,
    output logic [15:0]      ERR_BITS,
    output logic [CNT_W-1:0] WORD_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] BIT_ERR_CNT
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int MC_W  = $clog2(LOCK_CNT + 1);
    localparam int MS_W  = $clog2(LOSS_CNT + 1);
    // Sum is wide enough to hold an all-ones counter plus a full 16-bit popcount
    localparam int SUM_W = ((CNT_W > 5) ? CNT_W : 5) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [15:0] lfsr_nxt(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[14] ^ x[12] ^ x[3]};
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       state_r, state_s;
    logic [15:0]      exp_r, exp_s;
    logic [MC_W-1:0]  match_r, match_s;
    logic [MS_W-1:0]  miss_r, miss_s;
    logic             err_r, err_s;
    logic             locked_r;
    logic [15:0]      err_bits_r, err_bits_s;
    logic [CNT_W-1:0] word_cnt_r, word_cnt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
    logic [CNT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [4:0]       pop_s;
    logic [SUM_W-1:0] bsum_s;

    // Next-state, prediction and counter update for one sampled word
    always_comb begin
        state_s    = state_r;
        exp_s      = exp_r;
        match_s    = match_r;
        miss_s     = miss_r;
        err_s      = 1'b0;
        err_bits_s = err_bits_r;
        word_cnt_s = word_cnt_r;
        err_cnt_s  = err_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        pop_s      = popcount16(IN_DATA ^ exp_r);
        bsum_s     = SUM_W'(bit_cnt_r) + SUM_W'(pop_s);
        if (CLR) begin
            state_s    = ST_SEARCH;
            match_s    = '0;
            miss_s     = '0;
            err_bits_s = 16'h0000;
            word_cnt_s = '0;
            err_cnt_s  = '0;
            bit_cnt_s  = '0;
        end else if (IN_VALID) begin
            case (state_r)
                ST_SEARCH: begin
                    // All-zero is the LFSR lockup value and can never seed a valid stream
                    if (IN_DATA != 16'h0000) begin
                        exp_s   = lfsr_nxt(IN_DATA);
                        match_s = '0;
                        state_s = ST_VERIFY;
                    end else begin
                        state_s = ST_SEARCH;
                    end
                end
                ST_VERIFY: begin
                    if (IN_DATA == exp_r) begin
                        exp_s   = lfsr_nxt(exp_r);
                        match_s = match_r + MC_W'(1);
                        if (match_s == MC_W'(LOCK_CNT)) begin
                            state_s = ST_LOCKED;
                            miss_s  = '0;
                        end else begin
                            state_s = ST_VERIFY;
                        end
                    end else if (IN_DATA != 16'h0000) begin
                        exp_s   = lfsr_nxt(IN_DATA);
                        match_s = '0;
                        state_s = ST_VERIFY;
                    end else begin
                        match_s = '0;
                        state_s = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Prediction free-runs so a corrupted word never poisons later compares
                    word_cnt_s = sat_inc(word_cnt_r);
                    exp_s      = lfsr_nxt(exp_r);
                    err_bits_s = IN_DATA ^ exp_r;
                    if (IN_DATA == exp_r) begin
                        miss_s = '0;
                    end else begin
                        err_s     = 1'b1;
                        err_cnt_s = sat_inc(err_cnt_r);
                        if (bsum_s > SUM_W'(CNT_MAX)) begin
                            bit_cnt_s = CNT_MAX;
                        end else begin
                            bit_cnt_s = CNT_W'(bsum_s);
                        end
                        miss_s = miss_r + MS_W'(1);
                        if (miss_s == MS_W'(LOSS_CNT)) begin
                            state_s = ST_SEARCH;
                            miss_s  = '0;
                            match_s = '0;
                        end else begin
                            state_s = ST_LOCKED;
                        end
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                    match_s = '0;
                    miss_s  = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, prediction and output registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= ST_SEARCH;
            exp_r      <= 16'h0000;
            match_r    <= '0;
            miss_r     <= '0;
            err_r      <= 1'b0;
            locked_r   <= 1'b0;
            err_bits_r <= 16'h0000;
            word_cnt_r <= '0;
            err_cnt_r  <= '0;
            bit_cnt_r  <= '0;
        end else begin
            state_r    <= state_s;
            exp_r      <= exp_s;
            match_r    <= match_s;
            miss_r     <= miss_s;
            err_r      <= err_s;
            locked_r   <= (state_s == ST_LOCKED);
            err_bits_r <= err_bits_s;
            word_cnt_r <= word_cnt_s;
            err_cnt_r  <= err_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
        end
    end

    assign LOCKED      = locked_r;
    assign ERR         = err_r;
    assign ERR_BITS    = err_bits_r;
    assign WORD_CNT    = word_cnt_r;
    assign ERR_CNT     = err_cnt_r;
    assign BIT_ERR_CNT = bit_cnt_r;

endmodule
